// File: rtl/btn_debounce_if.sv
// Button-conditioner bus: raw pins in, debounced level and edge pulses out.
// The btn_long signal exists only when BTN_LONG_PRESS_EN is defined.
interface btn_debounce_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_lvl;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             any_press;
`ifdef BTN_LONG_PRESS_EN
  logic [N_BTN-1:0] btn_long;

  modport master (
    output btn_raw,
    input  btn_lvl, btn_press, btn_release, any_press, btn_long
  );
  modport slave (
    input  btn_raw,
    output btn_lvl, btn_press, btn_release, any_press, btn_long
  );
`else
  modport master (
    output btn_raw,
    input  btn_lvl, btn_press, btn_release, any_press
  );
  modport slave (
    input  btn_raw,
    output btn_lvl, btn_press, btn_release, any_press
  );
`endif
endinterface

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer: 2-flop synchroniser, per-channel filter FSM, press/release pulses.
// Optional long-press detector is enabled by defining BTN_LONG_PRESS_EN.
module btn_debounce #(
  parameter int N_BTN         = 4,
  parameter int STABLE_CYCLES = 1_000_000
`ifdef BTN_LONG_PRESS_EN
  , parameter int LONG_CYCLES = 100_000_000
`endif
) (
  input logic           clk,
  input logic           rst,
  btn_debounce_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  localparam logic [1:0] LOW_STABLE  = 2'd0;
  localparam logic [1:0] WAIT_HIGH   = 2'd1;
  localparam logic [1:0] HIGH_STABLE = 2'd2;
  localparam logic [1:0] WAIT_LOW    = 2'd3;

  logic [N_BTN-1:0] r_s1;
  logic [N_BTN-1:0] r_s2;
  logic [N_BTN-1:0] w_lvl;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_release;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse s1/s2 into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= bus.btn_raw;
      r_s2 <= r_s1;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  logic [N_BTN-1:0] w_long;
`endif

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_lvl;
    logic          r_press;
    logic          r_release;
    logic          w_in;
    logic          w_enter_high;
    logic          w_enter_low;

    assign w_in         = r_s2[g];
    assign w_enter_high = (r_state == WAIT_HIGH) &&  w_in && (r_cnt == CNT_LAST);
    assign w_enter_low  = (r_state == WAIT_LOW)  && !w_in && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state   <= LOW_STABLE;
        r_cnt     <= '0;
        r_lvl     <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        case (r_state)
          LOW_STABLE: begin
            if (w_in) begin
              r_state <= WAIT_HIGH;
              r_cnt   <= CW'(1);
            end
          end
          WAIT_HIGH: begin
            // Any reversal restarts filtering from the stable state without a pulse.
            if (!w_in) begin
              r_state <= LOW_STABLE;
              r_cnt   <= '0;
            end else if (w_enter_high) begin
              r_state <= HIGH_STABLE;
              r_lvl   <= 1'b1;
              r_press <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          HIGH_STABLE: begin
            if (!w_in) begin
              r_state <= WAIT_LOW;
              r_cnt   <= CW'(1);
            end
          end
          WAIT_LOW: begin
            if (w_in) begin
              r_state <= HIGH_STABLE;
              r_cnt   <= '0;
            end else if (w_enter_low) begin
              r_state   <= LOW_STABLE;
              r_lvl     <= 1'b0;
              r_release <= 1'b1;
              r_cnt     <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          default: begin
            r_state <= LOW_STABLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end

    assign w_lvl[g]     = r_lvl;
    assign w_press[g]   = r_press;
    assign w_release[g] = r_release;

`ifdef BTN_LONG_PRESS_EN
    logic [HW-1:0] r_hold;
    logic          r_long;
    logic          w_in_high;

    assign w_in_high = (r_state == HIGH_STABLE) || (r_state == WAIT_LOW);

    // Hold counter saturates one past the threshold so the pulse fires once per press.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_hold <= '0;
        r_long <= 1'b0;
      end else begin
        r_long <= w_in_high && (r_hold == HOLD_LAST);
        if (w_enter_high || w_enter_low) begin
          r_hold <= '0;
        end else if (w_in_high && (r_hold != HOLD_MAX)) begin
          r_hold <= r_hold + HW'(1);
        end
      end
    end

    assign w_long[g] = r_long;
`endif
  end

  assign bus.btn_lvl     = w_lvl;
  assign bus.btn_press   = w_press;
  assign bus.btn_release = w_release;
  assign bus.any_press   = |w_press;
`ifdef BTN_LONG_PRESS_EN
  assign bus.btn_long    = w_long;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Randomised self-checking bench for btn_debounce against a "consecutive disagreeing samples" model.
// Long-press checks are compiled in when BTN_LONG_PRESS_EN is defined.
module tb_btn_debounce;
  localparam int N    = 4;
  localparam int S    = 8;
  localparam int LONG = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btn_debounce_if #(.N_BTN(N)) bus ();

  btn_debounce #(
    .N_BTN(N),
    .STABLE_CYCLES(S)
`ifdef BTN_LONG_PRESS_EN
    , .LONG_CYCLES(LONG)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: 2-cycle delay line, then the level flips once the delayed
  // input has disagreed with it for S consecutive samples.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_press, m_rel, m_long;
  int m_run[N];
  int m_hold[N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i]  = 0;
      m_hold[i] = 0;
    end
  endtask

  task automatic tick();
    logic [N-1:0] d;
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_clear();
    end else begin
      d       = m_s2;
      m_s2    = m_s1;
      m_s1    = bus.btn_raw;
      m_press = '0;
      m_rel   = '0;
      m_long  = '0;
      for (int i = 0; i < N; i++) begin
        m_run[i] = (d[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
        if (m_lvl[i] && m_hold[i] == LONG - 1) m_long[i] = 1'b1;
        if (m_run[i] == S) begin
          m_run[i]  = 0;
          m_hold[i] = 0;
          if (m_lvl[i]) m_rel[i] = 1'b1;
          else          m_press[i] = 1'b1;
          m_lvl[i] = ~m_lvl[i];
        end else if (m_lvl[i] && m_hold[i] < LONG) begin
          m_hold[i]++;
        end
      end
    end
    #1;
    check("lvl",     32'(bus.btn_lvl),     32'(m_lvl));
    check("press",   32'(bus.btn_press),   32'(m_press));
    check("release", 32'(bus.btn_release), 32'(m_rel));
    check("any",     32'(bus.any_press),   32'(|m_press));
`ifdef BTN_LONG_PRESS_EN
    check("long",    32'(bus.btn_long),    32'(m_long));
`endif
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Edges from the sampling edge (counted as 1) to the press pulse, bounded.
  task automatic press_latency(input int ch, input string tag);
    int lat;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      lat++;
      if (bus.btn_press[ch]) break;
    end
    if (!bus.btn_press[ch]) lat = 99;
    check(tag, 32'(lat), 32'(S + 2));
  endtask

  initial begin
    int tmr[N];
    int any_cnt;
    logic [N-1:0] any_vec;
    logic [N-1:0] raw;

    model_clear();
    rst = 1'b1;
    bus.btn_raw = '0;
    ticks(3);
    rst = 1'b0;
    ticks(2);

    // Clean press on channel 0.
    bus.btn_raw = 4'b0001;
    press_latency(0, "clean_lat");
    ticks(5);
    check("clean_lvl", 32'(bus.btn_lvl), 32'h1);

    // Bounce on channel 1, then hold.
    for (int b = 0; b < 4; b++) begin
      bus.btn_raw[1] = (b % 2 == 0);
      ticks(3);
    end
    bus.btn_raw[1] = 1'b1;
    press_latency(1, "bounce_lat");
    ticks(3);

    // Short low glitch on channel 0, then a real release.
    bus.btn_raw[0] = 1'b0;
    ticks(5);
    bus.btn_raw[0] = 1'b1;
    ticks(12);
    check("glitch_lvl", 32'(bus.btn_lvl[0]), 32'h1);
    bus.btn_raw[0] = 1'b0;
    ticks(15);
    check("release_lvl", 32'(bus.btn_lvl[0]), 32'h0);

    // Simultaneous press on all channels.
    bus.btn_raw = '0;
    ticks(25);
    bus.btn_raw = '1;
    any_cnt = 0;
    any_vec = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.any_press) begin
        any_cnt++;
        any_vec = bus.btn_press;
      end
    end
    check("simul_any_cnt", 32'(any_cnt), 32'd1);
    check("simul_vec", 32'(any_vec), 32'hF);

    // Reset while channel 2 is mid-filter (cnt=5 in WAIT_HIGH).
    bus.btn_raw = '0;
    ticks(25);
    bus.btn_raw[2] = 1'b1;
    ticks(7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    press_latency(2, "rst_mid_lat");
    ticks(3);

    // Randomised bursts with occasional reset.
    for (int i = 0; i < N; i++) tmr[i] = 0;
    for (int c = 0; c < 2500; c++) begin
      raw = bus.btn_raw;
      for (int i = 0; i < N; i++) begin
        if (tmr[i] == 0) begin
          raw[i] = 1'($urandom_range(0, 1));
          tmr[i] = $urandom_range(1, 14);
        end else begin
          tmr[i]--;
        end
      end
      bus.btn_raw = raw;
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;

`ifdef BTN_LONG_PRESS_EN
    begin
      int p_cyc, l_cyc, l_cnt;
      bus.btn_raw = '0;
      ticks(25);
      bus.btn_raw[3] = 1'b1;
      p_cyc = -1; l_cyc = -1; l_cnt = 0;
      for (int k = 0; k < 60; k++) begin
        tick();
        if (bus.btn_press[3]) p_cyc = cyc;
        if (bus.btn_long[3]) begin
          l_cnt++;
          l_cyc = cyc;
        end
      end
      check("long_cnt", 32'(l_cnt), 32'd1);
      check("long_dist", 32'(l_cyc - p_cyc), 32'(LONG));
      bus.btn_raw[3] = 1'b0;
      ticks(30);
      l_cnt = 0;
      bus.btn_raw[3] = 1'b1;
      for (int k = 0; k < 15; k++) begin
        tick();
        if (bus.btn_long[3]) l_cnt++;
      end
      bus.btn_raw[3] = 1'b0;
      for (int k = 0; k < 30; k++) begin
        tick();
        if (bus.btn_long[3]) l_cnt++;
      end
      check("short_no_long", 32'(l_cnt), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
Multi-channel push-button conditioner that sits directly upstream of the strobe/LED counter stage. It synchronises raw asynchronous buttons to clk and filters contact bounce. It delivers a clean level plus single-cycle press/release pulses, which downstream logic uses as counter reset, enable or step inputs. Each channel has its own independent per-channel FSM and stability counter.

Parameters:
N_BTN, 4, number of independent button channels (1..16)
STABLE_CYCLES, 1_000_000, consecutive clk cycles the synchronised input must differ from the current level before the level flips (10 ms at 100 MHz); legal range 2..2^24
LONG_CYCLES, 100_000_000, hold time after press before long-press pulse (used only with the optional feature)

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  synchronous, active-high reset
btn_raw  input  N_BTN  raw button pins, asynchronous, active-high
btn_lvl  output  N_BTN  debounced level per channel
btn_press  output  N_BTN  1-cycle pulse on debounced rising edge
btn_release  output  N_BTN  1-cycle pulse on debounced falling edge
any_press  output  1  OR of btn_press, same cycle

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. With rst high at a clk edge, all of the following clear to 0: synchroniser flops, counters, btn_lvl, btn_press, btn_release, any_press. FSM goes to LOW_STABLE.
- Synchroniser: 2 flops per channel (s1, s2). The FSM uses only s2. Raw input is never used directly.
- Counter: cnt per channel, width $clog2(STABLE_CYCLES+1), unsigned. It never wraps; it saturates logically because the FSM exits at the threshold.
- FSM per channel, states LOW_STABLE, WAIT_HIGH, HIGH_STABLE, WAIT_LOW:
  - LOW_STABLE: btn_lvl=0. If s2=1, go to WAIT_HIGH with cnt=1.
  - WAIT_HIGH: btn_lvl=0.
    - If s2=0, return to LOW_STABLE with cnt=0. A glitch produces no pulse.
    - Else, if cnt==STABLE_CYCLES-1, go to HIGH_STABLE; btn_lvl<=1, btn_press<=1 for exactly one cycle, cnt<=0.
    - Else, cnt<=cnt+1.
  - HIGH_STABLE and WAIT_LOW: mirror of the above with polarity inverted; btn_release pulses on entry to LOW_STABLE.
- Latency: raw edge held stable → btn_lvl flips and the pulse asserts STABLE_CYCLES+2 clk edges after the first edge that samples the new raw value. There are 2 synchroniser cycles.
- Bounce: any s2 reversal during a WAIT state restarts filtering from the stable state. btn_lvl never toggles more than once per STABLE_CYCLES window.
- Pulses are registered outputs. btn_press and btn_release for a channel are mutually exclusive and never assert on consecutive cycles.
- Channels are fully independent. Simultaneous presses on several channels give same-cycle pulses; any_press=1 for that one cycle.
- Reset mid-operation (in a WAIT state or while held): state goes to LOW_STABLE, no pulse.
  - If the button is still held after reset, a fresh press pulse follows STABLE_CYCLES+2 cycles later.

Optional Feature:
Macro BTN_LONG_PRESS_EN.
- Defined: adds output btn_long [N_BTN] and a per-channel hold counter, width $clog2(LONG_CYCLES+1).
  - The hold counter clears on btn_press and increments each cycle in HIGH_STABLE or WAIT_LOW.
  - When it reaches LOW_CYCLES-1... specifically LONG_CYCLES-1, btn_long pulses for 1 cycle, at most once per press.
  - The counter holds until release, and clears on rst.
  - A bounce in WAIT_LOW that returns to HIGH_STABLE does not clear it.
- Undefined: the btn_long port, the hold counter and LONG_CYCLES logic are absent. Behaviour is otherwise identical.

Test Plan:
- Clean press: N_BTN=4, STABLE_CYCLES=8, rst 3 cycles, then btn_raw[0]=1 held → btn_press[0] is high for exactly 1 cycle, 10 edges after the sampling edge; btn_lvl[0]=1 after that; no other channel moves.
- Bounce rejection: btn_raw[1] toggles 1,0,1,0 every 3 cycles, then holds 1 → no pulse during bounce; one btn_press[1] 10 edges after the final rising sample.
- Release and glitch: with channel 0 high, a 5-cycle low glitch → no release. Then hold low → a single btn_release[0] 10 edges later; btn_lvl[0]=0.
- Simultaneous: btn_raw=4'b1111 on the same edge → btn_press=4'b1111 in one cycle; any_press=1 for exactly 1 cycle.
- Reset mid-filter: rst asserted at cnt=5 in WAIT_HIGH while held → no pulse; after rst drops, btn_press 10 edges later.
- BTN_LONG_PRESS_EN with LONG_CYCLES=20: hold 40 cycles after press → exactly one btn_long pulse, 20 cycles after btn_press; a short press of 15 cycles gives none.
